// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite bus bundle between a master and the SRAM slave.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite word SRAM slave with byte-lane writes and WAIT_STATES stall cycles per beat.
// Define AHB3LITE_SRAM_ERROR_EN to add the two-cycle ERROR response for bad transfers.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
)(
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb3lite_sram_slave_if.slave  bus
);
  localparam int BYTES = HDATA_SIZE / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int OFF_W = (BW > 0) ? BW : 1;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef AHB3LITE_SRAM_ERROR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

  state_t                r_state, w_acc_state;
  logic [3:0]            r_cnt;
  logic                  r_ready, r_write;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [BYTES-1:0]      r_be, w_be;
  logic [HDATA_SIZE-1:0] r_rdata, w_rword;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
  logic                  w_accept, w_load, w_err;
  int                    w_nbytes, w_off;
`ifdef AHB3LITE_SRAM_ERROR_EN
  logic                  r_resp;
`endif

  // Gating with r_ready keeps a stray HREADY from clobbering an in-flight data phase.
  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & r_ready;
  assign w_idx    = bus.HADDR[BW +: IDX_W];
  assign w_load   = w_accept & ~bus.HWRITE & ~w_err;

  always_comb begin
    w_nbytes = 1 << ((int'(bus.HSIZE) > BW) ? BW : int'(bus.HSIZE));
    w_off    = 0;
    if (BW > 0) w_off = int'(bus.HADDR[OFF_W-1:0]) & ~(w_nbytes - 1);
    w_be = '0;
    for (int b = 0; b < BYTES; b++)
      w_be[b] = (b >= w_off) && (b < w_off + w_nbytes);
  end

`ifdef AHB3LITE_SRAM_ERROR_EN
  always_comb begin
    w_err = (int'(bus.HSIZE) > BW)
         || ((bus.HADDR & HADDR_SIZE'((1 << bus.HSIZE) - 1)) != '0)
         || (64'(bus.HADDR) >= 64'(MEM_DEPTH) * 64'(BYTES));
  end
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_acc_state = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
`ifdef AHB3LITE_SRAM_ERROR_EN
    if (w_err) w_acc_state = S_ERR1;
`endif
  end

  // Read data is captured at the address phase; a write finishing on the same
  // edge to the same word is merged in lane by lane.
  always_comb begin
    w_rword = mem[w_idx];
    if (r_state == S_DATA && r_write && r_idx == w_idx)
      for (int b = 0; b < BYTES; b++)
        if (r_be[b]) w_rword[8*b +: 8] = bus.HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && r_state == S_DATA && r_write)
      for (int b = 0; b < BYTES; b++)
        if (r_be[b]) mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= bus.HWRITE;
        r_idx   <= w_idx;
        r_be    <= w_be;
      end
      if (w_load) r_rdata <= w_rword;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_cnt   <= 4'd0;
`ifdef AHB3LITE_SRAM_ERROR_EN
      r_resp  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DATA;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef AHB3LITE_SRAM_ERROR_EN
        S_ERR1: begin
          r_state <= S_ERR2;
          r_ready <= 1'b1;
        end
`endif
        default: begin
          if (w_accept) begin
            r_state <= w_acc_state;
            r_ready <= (w_acc_state == S_DATA);
            r_cnt   <= CNT_INIT;
`ifdef AHB3LITE_SRAM_ERROR_EN
            r_resp  <= w_err;
`endif
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
`ifdef AHB3LITE_SRAM_ERROR_EN
            r_resp  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign bus.HREADYOUT = r_ready;
  assign bus.HRDATA    = r_rdata;
`ifdef AHB3LITE_SRAM_ERROR_EN
  assign bus.HRESP     = r_resp;
`else
  assign bus.HRESP     = 1'b0;
`endif

  wire w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR};
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven through one shared pipelined driver.
module tb_ahb3lite_sram_slave;
`ifdef AHB3LITE_SRAM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        clk = 1'b0, rst = 1'b1, dut_sel = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [15:0] haddr = '0;
  logic [31:0] hwdata = '0, pend = '0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = T_IDLE;

  always #5 clk = ~clk;

  ahb3lite_sram_slave_if #(.HADDR_SIZE(16), .HDATA_SIZE(32)) b0 ();
  ahb3lite_sram_slave_if #(.HADDR_SIZE(16), .HDATA_SIZE(32)) b3 ();

  assign b0.HSEL = hsel & ~dut_sel;      assign b3.HSEL = hsel & dut_sel;
  assign b0.HADDR = haddr;               assign b3.HADDR = haddr;
  assign b0.HWDATA = hwdata;             assign b3.HWDATA = hwdata;
  assign b0.HWRITE = hwrite;             assign b3.HWRITE = hwrite;
  assign b0.HSIZE = hsize;               assign b3.HSIZE = hsize;
  assign b0.HBURST = 3'b011;             assign b3.HBURST = 3'b011;
  assign b0.HPROT = 4'b0011;             assign b3.HPROT = 4'b0011;
  assign b0.HTRANS = htrans;             assign b3.HTRANS = htrans;
  assign b0.HMASTLOCK = 1'b0;            assign b3.HMASTLOCK = 1'b0;
  assign b0.HREADY = b0.HREADYOUT;       assign b3.HREADY = b3.HREADYOUT;

  ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0))
    u_ws0 (.HCLK(clk), .HRESET(rst), .bus(b0.slave));
  ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3))
    u_ws3 (.HCLK(clk), .HRESET(rst), .bus(b3.slave));

  wire        w_ready = dut_sel ? b3.HREADYOUT : b0.HREADYOUT;
  wire        w_resp  = dut_sel ? b3.HRESP     : b0.HRESP;
  wire [31:0] w_rdata = dut_sel ? b3.HRDATA    : b0.HRDATA;

  typedef struct {
    int          id;
    bit          is_rd;
    logic [31:0] data;
    bit          resp;
    int          waits;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;
  int   n_chk = 0, n_fail = 0, beat_id = 0, m_waits = 0;
  bit   m_busy = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: tracks the data phase from the bus and retires one expectation per completed beat.
  always @(negedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_waits = 0;
      sbq.delete();
    end else begin
      if (m_busy) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty: data phase seen with no expectation queued");
          m_busy = 1'b0;
        end else if (!w_ready) begin
          m_waits++;
          check($sformatf("beat%0d resp_in_wait", sbq[0].id), 32'(w_resp), 32'(sbq[0].resp));
        end else begin
          m_e = sbq.pop_front();
          check($sformatf("beat%0d resp", m_e.id), 32'(w_resp), 32'(m_e.resp));
          check($sformatf("beat%0d wait_cycles", m_e.id), 32'(m_waits), 32'(m_e.waits));
          if (m_e.is_rd) check($sformatf("beat%0d rdata", m_e.id), w_rdata, m_e.data);
          m_busy  = 1'b0;
          m_waits = 0;
        end
      end else begin
        check("idle_ready", 32'(w_ready), 32'd1);
        check("idle_resp", 32'(w_resp), 32'd0);
      end
      if (hsel && htrans[1] && w_ready) m_busy = 1'b1;
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_ready && n < 40);
    if (!w_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: HREADYOUT low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1;
  endtask

  // One address-phase slot; HWDATA carries the previous accepted write's data.
  task automatic beat(input bit s, input logic [15:0] a, input bit w, input logic [2:0] sz,
                      input logic [1:0] tr, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input bit exp_resp, input int exp_waits);
    hsel = s; haddr = a; hwrite = w; hsize = sz; htrans = tr; hwdata = pend;
    if (s && tr[1]) begin
      beat_id++;
      sbq.push_back('{id: beat_id, is_rd: !w, data: exp_rd, resp: exp_resp, waits: exp_waits});
    end
    wait_ready();
    pend = (s && tr[1] && w) ? wd : 32'h0;
  endtask

  task automatic do_wr(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd,
                       input bit er, input int ws);
    beat(1'b1, a, 1'b1, sz, T_NSEQ, wd, 32'h0, er, ws);
  endtask

  task automatic do_rd(input logic [15:0] a, input logic [31:0] exp, input int ws);
    beat(1'b1, a, 1'b0, 3'd2, T_NSEQ, 32'h0, exp, 1'b0, ws);
  endtask

  task automatic do_idle();
    beat(1'b0, 16'h0, 1'b0, 3'd2, T_IDLE, 32'h0, 32'h0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready_ws0", 32'(b0.HREADYOUT), 32'd1);
    check("rst_resp_ws0",  32'(b0.HRESP),     32'd0);
    check("rst_rdata_ws0", b0.HRDATA,         32'h0);
    check("rst_ready_ws3", 32'(b3.HREADYOUT), 32'd1);
    check("rst_resp_ws3",  32'(b3.HRESP),     32'd0);
    check("rst_rdata_ws3", b3.HRDATA,         32'h0);

    // zero-wait slave: word write then back-to-back read (forwarded)
    dut_sel = 1'b0;
    do_wr(16'h0010, 3'd2, 32'hDEADBEEF, 1'b0, 0);
    do_rd(16'h0010, 32'hDEADBEEF, 0);
    // byte and halfword lane writes
    do_wr(16'h0010, 3'd2, 32'h11223344, 1'b0, 0);
    do_wr(16'h0011, 3'd0, 32'hAAAAAAAA, 1'b0, 0);
    do_idle();
    do_rd(16'h0010, 32'h1122AA44, 0);
    do_wr(16'h0012, 3'd1, 32'h99887766, 1'b0, 0);
    do_idle();
    do_rd(16'h0010, 32'h9988AA44, 0);
    // byte write immediately followed by a read of the same word
    do_wr(16'h0030, 3'd2, 32'hCAFEF00D, 1'b0, 0);
    do_idle();
    do_wr(16'h0030, 3'd0, 32'h55555555, 1'b0, 0);
    do_rd(16'h0030, 32'hCAFEF055, 0);
    // BUSY and deselected slots are not transfers
    do_wr(16'h0040, 3'd2, 32'h0BADCAFE, 1'b0, 0);
    beat(1'b1, 16'h0044, 1'b1, 3'd2, T_BUSY, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
    beat(1'b0, 16'h0040, 1'b1, 3'd2, T_NSEQ, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
    do_idle();
    do_rd(16'h0040, 32'h0BADCAFE, 0);
    // HSIZE wider than the bus
    do_wr(16'h0060, 3'd2, 32'h00000000, 1'b0, 0);
    do_wr(16'h0060, 3'd3, 32'h13572468, ERR_EN, ERR_EN ? 1 : 0);
    do_idle();
    do_rd(16'h0060, ERR_EN ? 32'h0 : 32'h13572468, 0);
    // misaligned and out-of-range word writes
    do_wr(16'h0000, 3'd2, 32'h00001111, 1'b0, 0);
    do_wr(16'h0402, 3'd2, 32'hA5A5A5A5, ERR_EN, ERR_EN ? 1 : 0);
    do_wr(16'h0400, 3'd2, 32'h5A5A5A5A, ERR_EN, ERR_EN ? 1 : 0);
    do_rd(16'h0000, ERR_EN ? 32'h00001111 : 32'h5A5A5A5A, 0);
    do_idle();

    // three-wait-state slave: INCR4 write then INCR4 read
    dut_sel = 1'b1;
    do_idle();
    beat(1'b1, 16'h0020, 1'b1, 3'd2, T_NSEQ, 32'd1, 32'h0, 1'b0, 3);
    beat(1'b1, 16'h0024, 1'b1, 3'd2, T_SEQ,  32'd2, 32'h0, 1'b0, 3);
    beat(1'b1, 16'h0028, 1'b1, 3'd2, T_SEQ,  32'd3, 32'h0, 1'b0, 3);
    beat(1'b1, 16'h002C, 1'b1, 3'd2, T_SEQ,  32'd4, 32'h0, 1'b0, 3);
    beat(1'b1, 16'h0020, 1'b0, 3'd2, T_NSEQ, 32'h0, 32'd1, 1'b0, 3);
    beat(1'b1, 16'h0024, 1'b0, 3'd2, T_SEQ,  32'h0, 32'd2, 1'b0, 3);
    beat(1'b1, 16'h0028, 1'b0, 3'd2, T_SEQ,  32'h0, 32'd3, 1'b0, 3);
    beat(1'b1, 16'h002C, 1'b0, 3'd2, T_SEQ,  32'h0, 32'd4, 1'b0, 3);
    do_idle();

    // reset during a wait cycle drops the pending write
    do_wr(16'h0050, 3'd2, 32'h12345678, 1'b0, 3);
    do_idle();
    do_wr(16'h0050, 3'd2, 32'h77777777, 1'b0, 3);
    hsel = 1'b0; htrans = T_IDLE; hwdata = pend;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pend = 32'h0;
    check("ready_after_reset", 32'(b3.HREADYOUT), 32'd1);
    check("rdata_after_reset", b3.HRDATA, 32'h0);
    do_rd(16'h0050, 32'h12345678, 3);
    do_idle();
    do_idle();

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
